// File: rtl/upec_miter_ctrl.sv
// Run sequencer for the two-instance UPEC miter: chip reset, secret window,
// observation window with per-group equality checking and first-failure capture.
module upec_miter_ctrl #(
   parameter int NumGroups   = 8,
   parameter int CntW        = 16,
   parameter int ResetCycles = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [CntW-1:0]      secret_cycles_i,
   input  logic [CntW-1:0]      obs_cycles_i,
   input  logic [NumGroups-1:0] grp_mask_i,
   input  logic [NumGroups-1:0] grp_eq_i,
   output logic                 chip_rst_no,
   output logic                 secret_window_o,
   output logic                 obs_window_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 pass_o,
   output logic                 fail_o,
   output logic [NumGroups-1:0] fail_grp_o,
   output logic [CntW-1:0]      fail_cycle_o
);

   typedef enum logic [2:0] {IDLE, RST, SECRET, OBS, DONE} state_e;

   localparam logic [CntW-1:0] RstLast = CntW'(ResetCycles - 1);

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d, cnt_inc;
   logic [CntW-1:0]      sec_q, sec_d, obs_q, obs_d;
   logic [NumGroups-1:0] mask_q, mask_d, miss;
   logic [NumGroups-1:0] fail_grp_d;
   logic [CntW-1:0]      fail_cycle_d;
   logic                 pass_d, fail_d;

   assign miss    = ~grp_eq_i & mask_q;
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sec_d        = sec_q;
      obs_d        = obs_q;
      mask_d       = mask_q;
      pass_d       = pass_o;
      fail_d       = fail_o;
      fail_grp_d   = fail_grp_o;
      fail_cycle_d = fail_cycle_o;
      unique case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               state_d      = RST;
               cnt_d        = '0;
               sec_d        = secret_cycles_i;
               obs_d        = obs_cycles_i;
               mask_d       = grp_mask_i;
               pass_d       = 1'b0;
               fail_d       = 1'b0;
               fail_grp_d   = '0;
               fail_cycle_d = '0;
            end
         end
         RST: begin
            if (cnt_q == RstLast) begin
               cnt_d   = '0;
               state_d = (sec_q != '0) ? SECRET : OBS;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         SECRET: begin
            if (cnt_q == sec_q - 1'b1) begin
               cnt_d   = '0;
               state_d = OBS;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         OBS: begin
            // An empty observation window is a single compare-free cycle.
            if (obs_q != '0 && miss != '0) begin
               state_d      = DONE;
               fail_d       = 1'b1;
               fail_grp_d   = miss;
               fail_cycle_d = cnt_q;
            end else if (obs_q == '0 || cnt_q == obs_q - 1'b1) begin
               state_d = DONE;
               pass_d  = 1'b1;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: state_d = IDLE;
      endcase
      // Abort overrides whatever the busy phase decided this cycle.
      if (abort_i && (state_q == RST || state_q == SECRET || state_q == OBS)) begin
         state_d      = DONE;
         pass_d       = 1'b0;
         fail_d       = 1'b0;
         fail_grp_d   = fail_grp_o;
         fail_cycle_d = fail_cycle_o;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         sec_q           <= '0;
         obs_q           <= '0;
         mask_q          <= '0;
         chip_rst_no     <= 1'b0;
         secret_window_o <= 1'b0;
         obs_window_o    <= 1'b0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         pass_o          <= 1'b0;
         fail_o          <= 1'b0;
         fail_grp_o      <= '0;
         fail_cycle_o    <= '0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         sec_q           <= sec_d;
         obs_q           <= obs_d;
         mask_q          <= mask_d;
         chip_rst_no     <= (state_d == SECRET) || (state_d == OBS) || (state_d == DONE);
         secret_window_o <= (state_d == SECRET);
         obs_window_o    <= (state_d == OBS);
         busy_o          <= (state_d == RST) || (state_d == SECRET) || (state_d == OBS);
         done_o          <= (state_d == DONE);
         pass_o          <= pass_d;
         fail_o          <= fail_d;
         fail_grp_o      <= fail_grp_d;
         fail_cycle_o    <= fail_cycle_d;
      end
   end

endmodule

// File: tb/tb_upec_miter_ctrl.sv
// Bench for upec_miter_ctrl: timeline model of each run checked every cycle,
// plus directed runs with hand-computed expectations.
module tb_upec_miter_ctrl;
   localparam int NG = 8;
   localparam int CW = 16;
   localparam int RC = 4;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1, start_i = 1'b0, abort_i = 1'b0;
   logic [CW-1:0] secret_cycles_i = '0, obs_cycles_i = '0;
   logic [NG-1:0] grp_mask_i = '0, grp_eq_i = 8'hFF;
   logic          chip_rst_no, secret_window_o, obs_window_o, busy_o, done_o, pass_o, fail_o;
   logic [NG-1:0] fail_grp_o;
   logic [CW-1:0] fail_cycle_o;

   int n_tests = 0, n_fail = 0;

   upec_miter_ctrl #(.NumGroups(NG), .CntW(CW), .ResetCycles(RC)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
      .secret_cycles_i(secret_cycles_i), .obs_cycles_i(obs_cycles_i),
      .grp_mask_i(grp_mask_i), .grp_eq_i(grp_eq_i),
      .chip_rst_no(chip_rst_no), .secret_window_o(secret_window_o),
      .obs_window_o(obs_window_o), .busy_o(busy_o), .done_o(done_o),
      .pass_o(pass_o), .fail_o(fail_o), .fail_grp_o(fail_grp_o),
      .fail_cycle_o(fail_cycle_o));

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: a run is a timeline of RC reset cycles, S secret cycles, then the
   // observation window; m_age is the 0-based cycle number within the run.
   int m_st = 0;   // 0 idle, 1 running, 2 done
   int m_age = 0, m_s = 0, m_o = 0;
   int m_mask = 0, m_pass = 0, m_fail = 0, m_grp = 0, m_cyc = 0;
   bit m_valid = 0;

   always @(posedge clk) begin
      int miss;
      if (rst_i) begin
         m_st = 0; m_age = 0; m_s = 0; m_o = 0; m_mask = 0;
         m_pass = 0; m_fail = 0; m_grp = 0; m_cyc = 0; m_valid = 1;
      end else if (m_st != 1) begin
         if (start_i) begin
            m_st = 1; m_age = 0; m_s = int'(secret_cycles_i); m_o = int'(obs_cycles_i);
            m_mask = int'(grp_mask_i); m_pass = 0; m_fail = 0; m_grp = 0; m_cyc = 0;
         end
      end else if (abort_i) begin
         m_st = 2; m_pass = 0; m_fail = 0;
      end else if (m_age < RC + m_s) begin
         m_age++;
      end else begin
         miss = ~int'(grp_eq_i) & m_mask & 8'hFF;
         if (m_o != 0 && miss != 0) begin
            m_st = 2; m_fail = 1; m_grp = miss; m_cyc = m_age - RC - m_s;
         end else if (m_o == 0 || m_age - RC - m_s == m_o - 1) begin
            m_st = 2; m_pass = 1;
         end else begin
            m_age++;
         end
      end
   end

   always @(negedge clk) begin
      bit run;
      if (m_valid) begin
         run = (m_st == 1);
         chk("chip_rst_no", chip_rst_no, (run && m_age >= RC) || m_st == 2);
         chk("secret_window", secret_window_o, run && m_age >= RC && m_age < RC + m_s);
         chk("obs_window", obs_window_o, run && m_age >= RC + m_s);
         chk("busy", busy_o, run);
         chk("done", done_o, m_st == 2);
         chk("pass", pass_o, m_pass);
         chk("fail", fail_o, m_fail);
         chk("fail_grp", fail_grp_o, m_grp);
         chk("fail_cycle", fail_cycle_o, m_cyc);
      end
   end

   task automatic start_run(input int s, input int o, input logic [NG-1:0] mask);
      @(negedge clk);
      secret_cycles_i = CW'(s); obs_cycles_i = CW'(o); grp_mask_i = mask; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   // Count phase cycles until done; grp_eq is base_eq except bad_eq at obs index bad_idx.
   task automatic wait_done(input logic [NG-1:0] base_eq, input int bad_idx,
                            input logic [NG-1:0] bad_eq, output int nrst,
                            output int nsec, output int nobs);
      bit fin = 0;
      nrst = 0; nsec = 0; nobs = 0;
      for (int k = 0; k < 300; k++) begin
         if (done_o) begin fin = 1; break; end
         if (busy_o && !chip_rst_no) nrst++;
         if (secret_window_o) nsec++;
         if (obs_window_o) begin
            grp_eq_i = (nobs == bad_idx) ? bad_eq : base_eq;
            nobs++;
         end else begin
            grp_eq_i = base_eq;
         end
         @(negedge clk);
      end
      grp_eq_i = 8'hFF;
      if (!fin) chk("run_timeout", 0, 1);
   endtask

   int nr, ns, no;

   initial begin
      rst_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_chip_rst_no", chip_rst_no, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      rst_i = 1'b0;

      start_run(3, 5, 8'hFF);
      wait_done(8'hFF, -1, 8'hFF, nr, ns, no);
      chk("t1_rst_len", nr, 4); chk("t1_sec_len", ns, 3); chk("t1_obs_len", no, 5);
      chk("t1_pass", pass_o, 1); chk("t1_done", done_o, 1);

      start_run(3, 5, 8'hFF);
      wait_done(8'hFF, 2, 8'hF7, nr, ns, no);
      chk("t2_fail", fail_o, 1); chk("t2_pass", pass_o, 0);
      chk("t2_grp", fail_grp_o, 8'h08); chk("t2_cycle", fail_cycle_o, 2);
      chk("t2_obs_len", no, 3);

      start_run(3, 5, 8'hF7);
      wait_done(8'hF7, -1, 8'hF7, nr, ns, no);
      chk("t3_pass", pass_o, 1); chk("t3_fail", fail_o, 0);

      start_run(0, 0, 8'hFF);
      wait_done(8'h00, -1, 8'h00, nr, ns, no);
      chk("t4_rst_len", nr, 4); chk("t4_sec_len", ns, 0); chk("t4_obs_len", no, 1);
      chk("t4_pass", pass_o, 1);

      start_run(6, 5, 8'hFF);
      for (int k = 0; k < 50 && !secret_window_o; k++) @(negedge clk);
      chk("t5_in_secret", secret_window_o, 1);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      chk("t5_done", done_o, 1); chk("t5_pass", pass_o, 0); chk("t5_fail", fail_o, 0);
      start_run(1, 2, 8'hFF);
      chk("t5_cleared", pass_o, 0);
      wait_done(8'hFF, -1, 8'hFF, nr, ns, no);
      chk("t5_rst_len", nr, 4); chk("t5_pass2", pass_o, 1);

      start_run(2, 5, 8'hFF);
      for (int k = 0; k < 50 && !obs_window_o; k++) @(negedge clk);
      @(negedge clk);
      chk("t6_obs_idx1", obs_window_o, 1);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      chk("t6_chip_rst", chip_rst_no, 0); chk("t6_busy", busy_o, 0);
      chk("t6_grp", fail_grp_o, 0); chk("t6_cyc", fail_cycle_o, 0);
      chk("t6_pass", pass_o, 0);

      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rst_i           = ($urandom_range(0, 99) == 0);
         start_i         = ($urandom_range(0, 5) == 0);
         abort_i         = ($urandom_range(0, 29) == 0);
         secret_cycles_i = CW'($urandom_range(0, 3));
         obs_cycles_i    = CW'($urandom_range(0, 6));
         grp_mask_i      = ($urandom_range(0, 2) == 0) ? NG'($urandom) : 8'hFF;
         grp_eq_i        = ($urandom_range(0, 9) == 0) ? NG'($urandom) : 8'hFF;
      end
      @(negedge clk);
      rst_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
